// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: multi-cycle sequencer for LM/SM (load/store multiple).
// On a start pulse it captures a register mask, base address and direction,
// then moves one register per memory transaction, in ascending order R0..R7,
// between the 8x16 register file and data memory. The pipeline stalls on busy.
//
// Memory handshake: mem_req acts as "valid" and mem_ack as "ready/complete".
// A transfer happens in exactly the cycles where mem_req and mem_ack are both 1.
// Once mem_req is raised, mem_req, mem_we and mem_addr stay unchanged until that
// cycle. mem_ack may be high in the first cycle of a request. There is no idle
// cycle between two transfers of the same sequence.

module lmsm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        reg_mask,
    output logic              busy,
    output logic              done,
    output logic [2:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  mask_q;      // registers still to be transferred
    logic        store_q;     // captured direction: 1 = SM, 0 = LM
    logic [2:0]  cur_idx;     // lowest set bit of mask_q
    logic [7:0]  mask_rest;   // mask_q with its lowest set bit cleared
    logic        in_xfer;
    logic        xfer_store;
    logic        xfer_load;

    // Priority encoder: pick the lowest-numbered register still pending.
    always_comb begin
        cur_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_idx = 3'(i);
            end
        end
    end

    // Clearing the lowest set bit is x & (x - 1), independent of cur_idx.
    assign mask_rest = mask_q & (mask_q - 8'd1);

    assign in_xfer    = (state == S_XFER);
    assign xfer_store = in_xfer && store_q;
    assign xfer_load  = in_xfer && !store_q;

    // Sequencer FSM. mem_addr doubles as the running address register: it is
    // loaded with base_addr on start and stepped after every acknowledged
    // transfer, so only selected registers consume an address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mask_q   <= 8'd0;
            store_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_q  <= reg_mask;
                        store_q <= is_store;
                        busy    <= 1'b1;
                        if (reg_mask != 8'd0) begin
                            state    <= S_XFER;
                            mem_req  <= 1'b1;
                            mem_we   <= is_store;
                            mem_addr <= base_addr;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (mem_ack) begin
                        mask_q <= mask_rest;
                        if (mask_rest == 8'd0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(ADDR_STEP);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

    // Register-file side: stores read the current register and pass it straight
    // to memory; loads write memory data back on the same edge as the ack.
    always_comb begin
        rf_raddr  = xfer_store ? cur_idx : 3'd0;
        mem_wdata = xfer_store ? rf_rdata : '0;
        rf_we     = xfer_load && mem_ack;
        rf_waddr  = xfer_load ? cur_idx : 3'd0;
        rf_wdata  = xfer_load ? mem_rdata : '0;
        dbg_state = state;
    end

endmodule
